// File: rtl/llc_input_arbiter.sv
// N-channel input selector for the LLC front end: fixed priority with starvation
// promotion, registered grant/tag/set for the lookup stage, and single stalled-line tracking.
module llc_input_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int LINE_ADDR_BITS = 26,
    parameter int SET_BITS       = 10,
    parameter int STARVE_LIMIT   = 15,
    parameter int CNT_BITS       = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               decode_en,
    input  logic [NUM_CH-1:0]                  ch_valid,
    input  logic [NUM_CH-1:0]                  ch_block,
    input  logic [NUM_CH*LINE_ADDR_BITS-1:0]   ch_addr,
    input  logic                               recall_pending,
    input  logic                               stall_load,
    input  logic [SET_BITS-1:0]                stall_set_in,
    input  logic [LINE_ADDR_BITS-SET_BITS-1:0] stall_tag_in,
    output logic [NUM_CH-1:0]                  ch_pop,
    output logic [SET_BITS-1:0]                set_next,
    output logic [NUM_CH-1:0]                  grant_oh,
    output logic                               grant_valid,
    output logic [LINE_ADDR_BITS-SET_BITS-1:0] tag,
    output logic [SET_BITS-1:0]                set,
    output logic                               look,
    output logic                               stall_valid,
    output logic                               stall_clr,
    output logic [NUM_CH-1:0]                  starved
);

    localparam int TAG_BITS = LINE_ADDR_BITS - SET_BITS;

    logic [NUM_CH-1:0]         elig;
    logic [NUM_CH-1:0]         prio_req;
    logic [NUM_CH-1:0]         winner;
    logic                      found;
    logic [LINE_ADDR_BITS-1:0] win_addr;

    logic [CNT_BITS-1:0]       wait_cnt_q [NUM_CH];
    logic [CNT_BITS-1:0]       wait_cnt_d [NUM_CH];

    logic [NUM_CH-1:0]         grant_oh_q;
    logic                      grant_valid_q;
    logic [TAG_BITS-1:0]       tag_q;
    logic [SET_BITS-1:0]       set_q;
    logic                      stall_valid_q;
    logic [TAG_BITS-1:0]       stall_tag_q;
    logic [SET_BITS-1:0]       stall_set_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        elig    = '0;
        starved = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig[i]    = ch_valid[i] & ~ch_block[i] & (~recall_pending | (i == 0));
            starved[i] = (wait_cnt_q[i] == CNT_BITS'(STARVE_LIMIT));
        end
        prio_req = (|(elig & starved)) ? (elig & starved) : elig;
    end

    // Gating with rst keeps the pop quiet while reset is asserted mid-slot.
    always_comb begin
        winner   = '0;
        win_addr = '0;
        found    = 1'b0;
        if (decode_en && rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (prio_req[i] && !found) begin
                    winner[i] = 1'b1;
                    win_addr  = ch_addr[i*LINE_ADDR_BITS +: LINE_ADDR_BITS];
                    found     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (decode_en) begin
                if (winner[i] || !ch_valid[i]) begin
                    wait_cnt_d[i] = '0;
                end else if (elig[i] && wait_cnt_q[i] != CNT_BITS'(STARVE_LIMIT)) begin
                    wait_cnt_d[i] = wait_cnt_q[i] + CNT_BITS'(1);
                end
            end
        end
    end

    assign ch_pop    = winner;
    assign set_next  = win_addr[SET_BITS-1:0];
    assign stall_clr = found & stall_valid_q & (win_addr == {stall_tag_q, stall_set_q});

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_oh_q    <= '0;
            grant_valid_q <= 1'b0;
            tag_q         <= '0;
            set_q         <= '0;
            stall_valid_q <= 1'b0;
            stall_tag_q   <= '0;
            stall_set_q   <= '0;
            // NOTE: the counter array is tiny and must restart from zero, so it is reset like any register.
            for (int i = 0; i < NUM_CH; i++) wait_cnt_q[i] <= '0;
        end else begin
            if (decode_en) begin
                grant_oh_q    <= winner;
                grant_valid_q <= found;
                tag_q         <= win_addr[LINE_ADDR_BITS-1:SET_BITS];
                set_q         <= win_addr[SET_BITS-1:0];
            end
            // A fresh stall overrides a clear of the old line in the same cycle.
            if (stall_load) begin
                stall_valid_q <= 1'b1;
                stall_tag_q   <= stall_tag_in;
                stall_set_q   <= stall_set_in;
            end else if (stall_clr) begin
                stall_valid_q <= 1'b0;
            end
            for (int i = 0; i < NUM_CH; i++) wait_cnt_q[i] <= wait_cnt_d[i];
        end
    end

    assign grant_oh    = grant_oh_q;
    assign grant_valid = grant_valid_q;
    assign tag         = tag_q;
    assign set         = set_q;
    assign stall_valid = stall_valid_q;
    assign look        = grant_valid_q & ~recall_pending;

endmodule
